fetch_pc_predict: RTL and testbench
===================================

// Module: fetch_pc_predict
// PURPOSE
//  PC generation and IF/ID register for the 5-stage MIPS pipeline. It predecodes the fetched word and
//  selects the next PC using the strategy input (00 not-taken, 01 taken, 10 delay slot, 11 2-bit BHT).
//  It redirects on branch outcomes resolved in EX and feeds the ID stage.
// PARAMETERS
//  RESET_PC     32'd0  fetch address after reset
//  BHT_IDX_W    4      BHT index width; 2**BHT_IDX_W two-bit counters, indexed by pc[BHT_IDX_W+1:2]
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous, active-low reset
//  strategy       in   2   branch prediction strategy (encoding above)
//  stall          in   1   load-use hold from hazard unit
//  im_addr        out  32  instruction memory address (= pc)
//  im_rdata       in   32  instruction word, combinational read
//  ex_br_valid    in   1   beq/bne resolving in EX this cycle
//  ex_br_pc       in   32  address of the resolving branch
//  ex_br_taken    in   1   actual outcome
//  ex_br_target   in   32  actual taken target
//  ex_pred_taken  in   1   prediction carried with the branch (from ifid_pred_taken)
//  pc             out  32  current fetch PC
//  ifid_ir        out  32  IF/ID instruction
//  ifid_pc4       out  32  IF/ID PC+4
//  ifid_pred_taken out 1   IF/ID prediction bit
//  flush_id       out  1   squash the instruction in ID into a bubble at ID/EX (combinational)
// BEHAVIOUR
//  Reset (rst=0, async): pc=RESET_PC, ifid_ir=0 (NOP), ifid_pc4=0, ifid_pred_taken=0, jump_pending=0,
//   all BHT counters=2'b01. Release is synchronous to the next clk rise.
//  Predecode im_rdata:
//   - j (op 000010): target {pc4[31:28], imm26, 2'b00}.
//   - beq/bne (op 000100/000101): target pc4 + (sext(imm16)<<2).
//  Prediction for beq/bne: 00 -> 0; 01 -> 1; 10 -> 0; 11 -> BHT[idx][1].
//   The BHT read returns the pre-update value when the same index is updated in the same cycle.
//  Mispredict: mis = ex_br_valid & (ex_br_taken != ex_pred_taken).
//   - Redirect = ex_br_taken ? ex_br_target : ex_br_pc+4.
//  Next-PC priority (highest first):
//   1. mis: pc<=redirect; IF/ID<=NOP with pred 0; jump_pending<=0.
//      flush_id=1, except strategy 10 with taken outcome (delay slot in ID survives, flush_id=0).
//   2. stall: pc, IF/ID and jump_pending hold.
//   3. jump_pending: pc<=jp_target; jump_pending<=0.
//   4. j in IF:
//      - strategy 10: pc<=pc+4, jump_pending<=1, jp_target<=j target (slot fetched first).
//      - otherwise: pc<=j target.
//   5. predicted-taken branch: pc<=branch target.
//   6. else: pc<=pc+4.
//  IF/ID loads {im_rdata, pc+4, pred} when neither mis nor stall.
//  Jumps are never flushed; j targets are exact.
//  BHT update on every ex_br_valid, regardless of strategy: saturating increment if taken, decrement if not.
//  Changing strategy mid-run affects the next fetch only; in-flight pred bits still resolve correctly.
//  A branch or jump placed in a delay slot is unsupported; behaviour is undefined.
//  Arithmetic is 32-bit modulo; PC wraps silently. pc[1:0] is always 0.
// STRUCTURE
//  Shared package: opcode constants (OP_J, OP_BEQ, OP_BNE), strategy codes (STRAT_NT/T/DS/BHT), NOP word.
//  One sub-module: bht_2bit (counter array, read port, update port, async active-low reset).
// TESTING
//  - Reset held 3 cycles, then released: pc=0,4,8 on successive edges; ifid_ir=0 during reset.
//  - Strategy 00, beq at 20 (imm 16), EX resolves taken: flush_id=1 one cycle; next pc=88; ifid_ir=NOP.
//  - Strategy 01, beq at 32 (imm 11): next pc=80, ifid_pred_taken=1; resolve not-taken -> pc=36, flush_id=1.
//  - Strategy 10, j at 76 (target 28):
//    - pc sequence 76,80,28.
//    - a taken beq resolving in EX gives flush_id=0 and IF/ID=NOP.
//  - Strategy 11, beq at 60 resolved taken twice from reset: counter 01->10->11; next fetch predicts taken;
//    one not-taken result still predicts taken.
//  - stall=1 with a mispredict in the same cycle: redirect wins. Then stall=1 alone holds pc/ifid_ir 2 cycles.
//    rst low mid-run: pc=0 immediately, without a clk edge.

Source files
------------

// File: rtl/fetch_pc_predict_pkg.sv
// Shared definitions for the fetch stage: opcodes, prediction strategies, IF/ID payload
// and the two target-address helpers used by predecode.
package fetch_pc_predict_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    STRAT_NT  = 2'b00,
    STRAT_T   = 2'b01,
    STRAT_DS  = 2'b10,
    STRAT_BHT = 2'b11
  } strat_e;

  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc4;
    logic            pred;
  } ifid_t;

  // Jump target keeps the upper nibble of the delay-slot address.
  function automatic logic [XLEN-1:0] j_target(input logic [XLEN-1:0] pc4,
                                               input logic [25:0]     imm26);
    return {pc4[31:28], imm26, 2'b00};
  endfunction

  function automatic logic [XLEN-1:0] br_target(input logic [XLEN-1:0] pc4,
                                                input logic [15:0]     imm16);
    return pc4 + {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of saturating 2-bit counters; combinational read of the
// registered counters, so a same-cycle update is not visible until the next cycle.
module bht_2bit #(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_taken_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [1:0] ctr_q [DEPTH];
  logic [1:0] ctr_d [DEPTH];

  // Saturating update of the resolved branch's counter.
  always_comb begin
    ctr_d = ctr_q;
    if (upd_en_i) begin
      if (upd_taken_i && (ctr_q[upd_idx_i] != 2'b11)) begin
        ctr_d[upd_idx_i] = ctr_q[upd_idx_i] + 2'b01;
      end else if (!upd_taken_i && (ctr_q[upd_idx_i] != 2'b00)) begin
        ctr_d[upd_idx_i] = ctr_q[upd_idx_i] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign rd_taken_o = ctr_q[rd_idx_i][1];

endmodule

// File: rtl/fetch_pc_predict.sv
// PC generation and IF/ID register: predecodes the fetched word, predicts with the
// selected strategy, and redirects on branch mispredicts resolved in EX.
module fetch_pc_predict
  import fetch_pc_predict_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned BHT_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  strategy,
  input  logic        stall,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  input  logic        ex_br_valid,
  input  logic [31:0] ex_br_pc,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_target,
  input  logic        ex_pred_taken,
  output logic [31:0] pc,
  output logic [31:0] ifid_ir,
  output logic [31:0] ifid_pc4,
  output logic        ifid_pred_taken,
  output logic        flush_id
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] jp_tgt_q, jp_tgt_d;
  logic            jp_q, jp_d;
  ifid_t           ifid_q, ifid_d;

  logic [XLEN-1:0] pc4_c, j_tgt_c, br_tgt_c, redirect_c;
  logic [5:0]      op_c;
  logic            is_j_c, is_br_c, bht_taken_c, pred_c, mis_c;
  strat_e          strat_c;

  assign strat_c  = strat_e'(strategy);
  assign pc4_c    = pc_q + 32'd4;
  assign op_c     = im_rdata[31:26];
  assign is_j_c   = (op_c == OP_J);
  assign is_br_c  = (op_c == OP_BEQ) || (op_c == OP_BNE);
  assign j_tgt_c  = j_target(pc4_c, im_rdata[25:0]);
  assign br_tgt_c = br_target(pc4_c, im_rdata[15:0]);

  assign mis_c      = ex_br_valid && (ex_br_taken != ex_pred_taken);
  assign redirect_c = ex_br_taken ? ex_br_target : (ex_br_pc + 32'd4);

  // A taken branch under delay-slot mode keeps its slot instruction alive in ID.
  assign flush_id = mis_c && !((strat_c == STRAT_DS) && ex_br_taken);

  bht_2bit #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk         (clk),
    .rst_n       (rst),
    .rd_idx_i    (pc_q[BHT_IDX_W+1:2]),
    .rd_taken_o  (bht_taken_c),
    .upd_en_i    (ex_br_valid),
    .upd_idx_i   (ex_br_pc[BHT_IDX_W+1:2]),
    .upd_taken_i (ex_br_taken)
  );

  always_comb begin
    pred_c = 1'b0;
    if (is_br_c) begin
      case (strat_c)
        STRAT_NT:  pred_c = 1'b0;
        STRAT_T:   pred_c = 1'b1;
        STRAT_DS:  pred_c = 1'b0;
        STRAT_BHT: pred_c = bht_taken_c;
      endcase
    end
  end

  // Next-PC selection: mispredict > stall > pending jump > j > predicted branch > sequential.
  always_comb begin
    pc_d     = pc_q;
    ifid_d   = ifid_q;
    jp_d     = jp_q;
    jp_tgt_d = jp_tgt_q;
    if (mis_c) begin
      pc_d   = redirect_c;
      ifid_d = '{ir: NOP_WORD, pc4: '0, pred: 1'b0};
      jp_d   = 1'b0;
    end else if (!stall) begin
      ifid_d = '{ir: im_rdata, pc4: pc4_c, pred: pred_c};
      if (jp_q) begin
        pc_d = jp_tgt_q;
        jp_d = 1'b0;
      end else if (is_j_c) begin
        if (strat_c == STRAT_DS) begin
          pc_d     = pc4_c;
          jp_d     = 1'b1;
          jp_tgt_d = j_tgt_c;
        end else begin
          pc_d = j_tgt_c;
        end
      end else if (pred_c) begin
        pc_d = br_tgt_c;
      end else begin
        pc_d = pc4_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      ifid_q   <= '{ir: NOP_WORD, pc4: '0, pred: 1'b0};
      jp_q     <= 1'b0;
      jp_tgt_q <= '0;
    end else begin
      pc_q     <= pc_d;
      ifid_q   <= ifid_d;
      jp_q     <= jp_d;
      jp_tgt_q <= jp_tgt_d;
    end
  end

  assign pc              = pc_q;
  assign im_addr         = pc_q;
  assign ifid_ir         = ifid_q.ir;
  assign ifid_pc4        = ifid_q.pc4;
  assign ifid_pred_taken = ifid_q.pred;

endmodule

// File: tb/tb_fetch_pc_predict.sv
// Bench for fetch_pc_predict: directed scenarios with literal expectations, then random
// program/EX traffic checked every cycle against a behavioural fetch model.
`timescale 1ns/1ps
module tb_fetch_pc_predict;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  strategy;
  logic        stall;
  logic [31:0] im_addr, im_rdata;
  logic        ex_br_valid, ex_br_taken, ex_pred_taken;
  logic [31:0] ex_br_pc, ex_br_target;
  logic [31:0] pc, ifid_ir, ifid_pc4;
  logic        ifid_pred_taken, flush_id;

  localparam logic [31:0] ADDI = 32'h2108_0001;

  logic [31:0] mem [64];
  assign im_rdata = mem[im_addr[7:2]];

  always #5 clk = ~clk;

  fetch_pc_predict dut (
    .clk(clk), .rst(rst), .strategy(strategy), .stall(stall),
    .im_addr(im_addr), .im_rdata(im_rdata),
    .ex_br_valid(ex_br_valid), .ex_br_pc(ex_br_pc), .ex_br_taken(ex_br_taken),
    .ex_br_target(ex_br_target), .ex_pred_taken(ex_pred_taken),
    .pc(pc), .ifid_ir(ifid_ir), .ifid_pc4(ifid_pc4),
    .ifid_pred_taken(ifid_pred_taken), .flush_id(flush_id)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_ir, m_pc4, m_jpt;
  bit          m_pred, m_jp, e_flush, s_flush;
  int          m_bht [16];

  task automatic cmp32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_ir = 32'd0; m_pc4 = 32'd0; m_pred = 1'b0;
    m_jp = 1'b0; m_jpt = 32'd0;
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
  endtask

  task automatic check_outputs();
    cmp32("pc", pc, m_pc);
    cmp32("im_addr", im_addr, m_pc);
    cmp32("ifid_ir", ifid_ir, m_ir);
    cmp32("ifid_pc4", ifid_pc4, m_pc4);
    cmp32("ifid_pred", 32'(ifid_pred_taken), 32'(m_pred));
    cmp32("flush_id", 32'(flush_id), 32'(e_flush));
  endtask

  // One clock: drive at negedge, check, evaluate the model, commit after posedge.
  task automatic cyc(input logic [1:0] st, input bit sl, input bit v, input logic [31:0] bpc,
                     input bit tk, input logic [31:0] tgt, input bit pt);
    logic [31:0] w, pc4, jt, bt, n_pc, n_ir, n_pc4, n_jpt;
    bit          isj, isb, pr, mis, n_pred, n_jp;
    int          off, ui;
    @(negedge clk);
    strategy = st; stall = sl; ex_br_valid = v; ex_br_pc = bpc;
    ex_br_taken = tk; ex_br_target = tgt; ex_pred_taken = pt;
    #1;
    mis     = v && (tk != pt);
    e_flush = mis && !(st == 2'd2 && tk);
    check_outputs();
    s_flush = flush_id;
    w   = mem[m_pc[7:2]];
    pc4 = m_pc + 32'd4;
    isj = (w[31:26] == 6'd2);
    isb = (w[31:26] == 6'd4) || (w[31:26] == 6'd5);
    jt  = {pc4[31:28], w[25:0], 2'b00};
    off = int'($signed(w[15:0]));
    bt  = pc4 + 32'(off * 4);
    pr  = isb && (st == 2'd1 || (st == 2'd3 && m_bht[m_pc[5:2]] >= 2));
    n_pc = m_pc; n_ir = m_ir; n_pc4 = m_pc4; n_pred = m_pred; n_jp = m_jp; n_jpt = m_jpt;
    if (mis) begin
      n_pc = tk ? tgt : bpc + 32'd4;
      n_ir = 32'd0; n_pc4 = 32'd0; n_pred = 1'b0; n_jp = 1'b0;
    end else if (!sl) begin
      n_ir = w; n_pc4 = pc4; n_pred = pr;
      if (m_jp) begin n_pc = m_jpt; n_jp = 1'b0; end
      else if (isj && st == 2'd2) begin n_pc = pc4; n_jp = 1'b1; n_jpt = jt; end
      else if (isj) n_pc = jt;
      else if (pr) n_pc = bt;
      else n_pc = pc4;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_ir = n_ir; m_pc4 = n_pc4; m_pred = n_pred; m_jp = n_jp; m_jpt = n_jpt;
    if (v) begin
      ui = int'(bpc[5:2]);
      if (tk && m_bht[ui] < 3) m_bht[ui]++;
      else if (!tk && m_bht[ui] > 0) m_bht[ui]--;
    end
  endtask

  task automatic idle(input logic [1:0] st);
    cyc(st, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  // Force a fetch address with a taken mispredict from an unrelated branch.
  task automatic goto(input logic [31:0] a, input logic [1:0] st);
    cyc(st, 1'b0, 1'b1, 32'h100, 1'b1, a, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    cmp32("async_rst_pc", pc, 32'd0);
    cmp32("async_rst_ir", ifid_ir, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [15:0] imm;
    int          r;
    r   = int'($urandom_range(0, 5));
    imm = 16'($urandom_range(0, 63)) - 16'd32;
    case (r)
      0:       return {6'd2, 26'($urandom_range(0, 63))};
      1:       return {6'd4, 10'($urandom), imm};
      2:       return {6'd5, 10'($urandom), imm};
      default: return {6'($urandom_range(8, 63)), 26'($urandom)};
    endcase
  endfunction

  initial begin
    logic [1:0] cur_st;
    rst = 1'b0; strategy = 2'd0; stall = 1'b0; ex_br_valid = 1'b0; ex_br_pc = 32'd0;
    ex_br_taken = 1'b0; ex_br_target = 32'd0; ex_pred_taken = 1'b0; e_flush = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = ADDI;
    mem[5]  = 32'h1000_0010;  // beq at 20, imm 16
    mem[8]  = 32'h1000_000B;  // beq at 32, imm 11
    mem[15] = 32'h1000_0004;  // beq at 60, imm 4
    mem[19] = 32'h0800_0007;  // j at 76 -> 28
    model_reset();

    // Reset held for three edges, then release
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      cmp32("rst_pc", pc, 32'd0);
      cmp32("rst_ir", ifid_ir, 32'd0);
    end
    rst = 1'b1;
    cmp32("rel_pc0", pc, 32'd0);
    idle(2'd0); cmp32("rel_pc4", pc, 32'd4);
    idle(2'd0); cmp32("rel_pc8", pc, 32'd8);

    // Not-taken strategy, beq at 20 resolves taken
    repeat (5) idle(2'd0);
    cmp32("nt_pc28", pc, 32'd28);
    cyc(2'd0, 1'b0, 1'b1, 32'd20, 1'b1, 32'd88, 1'b0);
    cmp32("nt_flush", 32'(s_flush), 32'd1);
    cmp32("nt_pc", pc, 32'd88);
    cmp32("nt_ir", ifid_ir, 32'd0);

    // Always-taken strategy, beq at 32 then not-taken resolution
    goto(32'd32, 2'd1);
    idle(2'd1);
    cmp32("t_pc", pc, 32'd80);
    cmp32("t_ir", ifid_ir, 32'h1000_000B);
    cmp32("t_pc4", ifid_pc4, 32'd36);
    cmp32("t_pred", 32'(ifid_pred_taken), 32'd1);
    cyc(2'd1, 1'b0, 1'b1, 32'd32, 1'b0, 32'd80, 1'b1);
    cmp32("t_redir", pc, 32'd36);
    cmp32("t_flush", 32'(s_flush), 32'd1);

    // Delay-slot strategy, j at 76 to 28
    goto(32'd76, 2'd2);
    cmp32("ds_pc76", pc, 32'd76);
    idle(2'd2); cmp32("ds_pc80", pc, 32'd80);
    idle(2'd2); cmp32("ds_pc28", pc, 32'd28);
    cmp32("ds_slot", ifid_ir, ADDI);
    cyc(2'd2, 1'b0, 1'b1, 32'd28, 1'b1, 32'd200, 1'b0);
    cmp32("ds_flush", 32'(s_flush), 32'd0);
    cmp32("ds_ir", ifid_ir, 32'd0);
    cmp32("ds_pc", pc, 32'd200);

    // BHT strategy from reset, beq at 60
    do_reset();
    goto(32'd60, 2'd3);
    idle(2'd3);
    cmp32("bht_cold_pred", 32'(ifid_pred_taken), 32'd0);
    cmp32("bht_cold_pc", pc, 32'd64);
    cyc(2'd3, 1'b0, 1'b1, 32'd60, 1'b1, 32'd80, 1'b0);
    cyc(2'd3, 1'b0, 1'b1, 32'd60, 1'b1, 32'd80, 1'b0);
    goto(32'd60, 2'd3);
    idle(2'd3);
    cmp32("bht_hot_pred", 32'(ifid_pred_taken), 32'd1);
    cmp32("bht_hot_pc", pc, 32'd80);
    cyc(2'd3, 1'b0, 1'b1, 32'd60, 1'b0, 32'd64, 1'b1);
    cmp32("bht_nt_pc", pc, 32'd64);
    goto(32'd60, 2'd3);
    idle(2'd3);
    cmp32("bht_hyst_pred", 32'(ifid_pred_taken), 32'd1);

    // Stall with a mispredict: redirect wins; then stall alone holds
    cyc(2'd0, 1'b1, 1'b1, 32'h100, 1'b1, 32'd64, 1'b0);
    cmp32("stmis_pc", pc, 32'd64);
    cmp32("stmis_ir", ifid_ir, 32'd0);
    idle(2'd0);
    for (int i = 0; i < 2; i++) begin
      cyc(2'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      cmp32("stall_pc", pc, 32'd68);
      cmp32("stall_ir", ifid_ir, ADDI);
    end
    do_reset();

    // Random programs and EX traffic against the model
    for (int i = 0; i < 64; i++) mem[i] = rand_word();
    cur_st = 2'd0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 49) == 0) cur_st = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 599) == 0) do_reset();
      if ($urandom_range(0, 3) == 0)
        cyc(cur_st, $urandom_range(0, 7) == 0, 1'b1, 32'($urandom_range(0, 63)) << 2,
            1'($urandom), 32'($urandom_range(0, 63)) << 2, 1'($urandom));
      else
        cyc(cur_st, $urandom_range(0, 7) == 0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
